// File: rtl/mul_issue_sched_if.sv
// Issue-side bus between decode/issue and the multiply scheduler.
interface mul_issue_sched_if #(
  parameter int unsigned MUL_STAGES = 5,
  parameter int unsigned REG_ADDR   = 5
);
  localparam int unsigned CW = $clog2(MUL_STAGES + 1);

  logic                issue_valid;
  logic                issue_is_mul;
  logic                issue_regwrite;
  logic [REG_ADDR-1:0] issue_dst;
  logic [REG_ADDR-1:0] issue_rs;
  logic                issue_rs_used;
  logic [REG_ADDR-1:0] issue_rt;
  logic                issue_rt_used;
  logic                issue_stall;
  logic                mul_we;
  logic [CW-1:0]       inflight;
  logic                busy;
  logic                wb_valid;
  logic [REG_ADDR-1:0] wb_dst;

  modport master (
    output issue_valid, issue_is_mul, issue_regwrite, issue_dst,
           issue_rs, issue_rs_used, issue_rt, issue_rt_used,
    input  issue_stall, mul_we, inflight, busy, wb_valid, wb_dst
  );

  modport slave (
    input  issue_valid, issue_is_mul, issue_regwrite, issue_dst,
           issue_rs, issue_rs_used, issue_rt, issue_rt_used,
    output issue_stall, mul_we, inflight, busy, wb_valid, wb_dst
  );
endinterface

// File: rtl/mul_issue_sched.sv
// Multiply issue scheduler: shadow scoreboard of in-flight multiply destinations,
// RAW/WAW/writeback-collision stall generation and multiplier write-enable.
module mul_issue_sched #(
  parameter int unsigned MUL_STAGES = 5,
  parameter int unsigned ALU_LAT    = 2,
  parameter int unsigned REG_ADDR   = 5
) (
  input logic              clk,
  input logic              reset,
  mul_issue_sched_if.slave bus
);
  localparam int unsigned CW      = $clog2(MUL_STAGES + 1);
  localparam int unsigned COL_IDX = MUL_STAGES - ALU_LAT;

  logic [MUL_STAGES:1] valid_q, valid_d;
  logic [MUL_STAGES:1] rw_q, rw_d;
  logic [REG_ADDR-1:0] dst_q [1:MUL_STAGES];
  logic [REG_ADDR-1:0] dst_d [1:MUL_STAGES];
  logic [CW-1:0]       inflight_q, inflight_d;
  logic                busy_q, busy_d;
  logic                wb_valid_q, wb_valid_d;
  logic [REG_ADDR-1:0] wb_dst_q, wb_dst_d;

  logic raw, waw, col, stall, accept_mul;

  // Slot MUL_STAGES participates: there is no bypass to a same-cycle reader.
  function automatic logic match(input logic [REG_ADDR-1:0] r);
    logic m;
    m = 1'b0;
    for (int unsigned k = 1; k <= MUL_STAGES; k++)
      if (valid_q[k] && rw_q[k] && dst_q[k] == r) m = 1'b1;
    return m && (r != '0);
  endfunction

  always_comb begin
    raw = (bus.issue_rs_used && match(bus.issue_rs)) ||
          (bus.issue_rt_used && match(bus.issue_rt));
    waw = !bus.issue_is_mul && bus.issue_regwrite && match(bus.issue_dst);
    col = !bus.issue_is_mul && bus.issue_regwrite &&
          valid_q[COL_IDX] && rw_q[COL_IDX];
    stall      = bus.issue_valid && (raw || waw || col);
    accept_mul = bus.issue_valid && bus.issue_is_mul && !stall && !reset;
  end

  // The scoreboard shifts every cycle; stalls only insert bubbles at slot 1.
  always_comb begin
    valid_d = '0;
    rw_d    = '0;
    for (int unsigned k = 1; k <= MUL_STAGES; k++) dst_d[k] = '0;
    if (!reset) begin
      valid_d[1] = accept_mul;
      rw_d[1]    = accept_mul && bus.issue_regwrite;
      dst_d[1]   = accept_mul ? bus.issue_dst : '0;
      for (int unsigned k = 2; k <= MUL_STAGES; k++) begin
        valid_d[k] = valid_q[k-1];
        rw_d[k]    = rw_q[k-1];
        dst_d[k]   = dst_q[k-1];
      end
    end
    inflight_d = '0;
    for (int unsigned k = 1; k <= MUL_STAGES; k++)
      inflight_d = inflight_d + CW'(valid_d[k]);
    busy_d     = (inflight_d != '0);
    wb_valid_d = valid_d[MUL_STAGES] && rw_d[MUL_STAGES];
    wb_dst_d   = dst_d[MUL_STAGES];
  end

  always_ff @(posedge clk) begin
    valid_q    <= valid_d;
    rw_q       <= rw_d;
    for (int unsigned k = 1; k <= MUL_STAGES; k++) dst_q[k] <= dst_d[k];
    inflight_q <= inflight_d;
    busy_q     <= busy_d;
    wb_valid_q <= wb_valid_d;
    wb_dst_q   <= wb_dst_d;
  end

  assign bus.issue_stall = stall;
  assign bus.mul_we      = accept_mul;
  assign bus.inflight    = inflight_q;
  assign bus.busy        = busy_q;
  assign bus.wb_valid    = wb_valid_q;
  assign bus.wb_dst      = wb_dst_q;
endmodule

// File: tb/tb_mul_issue_sched.sv
// Directed bench for mul_issue_sched with hand-computed expectations.
module tb_mul_issue_sched;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  mul_issue_sched_if #(.MUL_STAGES(5), .REG_ADDR(5)) bus ();

  mul_issue_sched #(.MUL_STAGES(5), .ALU_LAT(2), .REG_ADDR(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic present(input logic v, input logic mul, input logic rw,
                         input logic [4:0] dst, input logic [4:0] rs, input logic rsu,
                         input logic [4:0] rt, input logic rtu);
    bus.issue_valid    = v;
    bus.issue_is_mul   = mul;
    bus.issue_regwrite = rw;
    bus.issue_dst      = dst;
    bus.issue_rs       = rs;
    bus.issue_rs_used  = rsu;
    bus.issue_rt       = rt;
    bus.issue_rt_used  = rtu;
    #1;
  endtask

  task automatic idle();
    present(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    idle();
    cyc(); cyc();
    // Reset state, and mul_we held low while reset even with a free multiply
    present(1'b1, 1'b1, 1'b1, 5'd3, 5'd1, 1'b1, 5'd2, 1'b1);
    chk("rst_mul_we", 32'(bus.mul_we), 0);
    chk("rst_inflight", 32'(bus.inflight), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_wb_valid", 32'(bus.wb_valid), 0);
    chk("rst_wb_dst", 32'(bus.wb_dst), 0);
    cyc();
    reset = 1'b0;
    idle();
    chk("rst_drop_inflight", 32'(bus.inflight), 0);

    // Back-to-back multiplies to r3, r4
    cyc(); present(1'b1, 1'b1, 1'b1, 5'd3, 5'd1, 1'b1, 5'd2, 1'b1);
    chk("b2b_we0", 32'(bus.mul_we), 1);
    chk("b2b_stall0", 32'(bus.issue_stall), 0);
    cyc(); present(1'b1, 1'b1, 1'b1, 5'd4, 5'd1, 1'b1, 5'd2, 1'b1);
    chk("b2b_we1", 32'(bus.mul_we), 1);
    chk("b2b_infl1", 32'(bus.inflight), 1);
    cyc(); idle();
    chk("b2b_infl2", 32'(bus.inflight), 2);
    chk("b2b_busy", 32'(bus.busy), 1);
    cyc(); cyc();
    chk("b2b_wbv4", 32'(bus.wb_valid), 0);
    cyc();
    chk("b2b_wbv5", 32'(bus.wb_valid), 1);
    chk("b2b_wbd5", 32'(bus.wb_dst), 3);
    chk("b2b_infl5", 32'(bus.inflight), 2);
    cyc();
    chk("b2b_wbv6", 32'(bus.wb_valid), 1);
    chk("b2b_wbd6", 32'(bus.wb_dst), 4);
    cyc();
    chk("b2b_wbv7", 32'(bus.wb_valid), 0);
    chk("b2b_infl7", 32'(bus.inflight), 0);
    chk("b2b_busy7", 32'(bus.busy), 0);

    // RAW: mul r5 then ADD reading r5 stalls 5 cycles
    cyc(); present(1'b1, 1'b1, 1'b1, 5'd5, 5'd1, 1'b1, 5'd2, 1'b1);
    chk("raw_we0", 32'(bus.mul_we), 1);
    for (int i = 1; i <= 5; i++) begin
      cyc(); present(1'b1, 1'b0, 1'b1, 5'd8, 5'd5, 1'b1, 5'd1, 1'b1);
      chk($sformatf("raw_stall%0d", i), 32'(bus.issue_stall), 1);
      chk($sformatf("raw_we%0d", i), 32'(bus.mul_we), 0);
    end
    chk("raw_infl5", 32'(bus.inflight), 1);
    cyc(); present(1'b1, 1'b0, 1'b1, 5'd8, 5'd5, 1'b1, 5'd1, 1'b1);
    chk("raw_stall6", 32'(bus.issue_stall), 0);
    chk("raw_infl6", 32'(bus.inflight), 0);

    // r0 never hazards; mul without regwrite is tracked but harmless
    cyc(); present(1'b1, 1'b1, 1'b1, 5'd0, 5'd1, 1'b1, 5'd2, 1'b1);
    cyc(); present(1'b1, 1'b1, 1'b0, 5'd10, 5'd1, 1'b1, 5'd2, 1'b1);
    chk("r0_rs_stall", 32'(bus.issue_stall), 0);
    cyc(); present(1'b1, 1'b0, 1'b1, 5'd9, 5'd0, 1'b1, 5'd10, 1'b1);
    chk("r0_add_stall", 32'(bus.issue_stall), 0);
    chk("norw_infl", 32'(bus.inflight), 2);
    cyc(); idle();
    for (int i = 0; i < 5; i++) cyc();
    chk("drain_infl", 32'(bus.inflight), 0);

    // Writeback collision with slot MUL_STAGES-ALU_LAT
    cyc(); present(1'b1, 1'b1, 1'b1, 5'd7, 5'd1, 1'b1, 5'd2, 1'b1);
    cyc(); idle();
    cyc(); idle();
    cyc(); present(1'b1, 1'b0, 1'b1, 5'd9, 5'd1, 1'b1, 5'd2, 1'b1);
    chk("col_stall3", 32'(bus.issue_stall), 1);
    cyc(); present(1'b1, 1'b0, 1'b1, 5'd9, 5'd1, 1'b1, 5'd2, 1'b1);
    chk("col_stall4", 32'(bus.issue_stall), 0);
    cyc(); idle();
    cyc(); idle();

    // WAW: mul r6 then SUB writing r6 without sources
    cyc(); present(1'b1, 1'b1, 1'b1, 5'd6, 5'd1, 1'b1, 5'd2, 1'b1);
    for (int i = 1; i <= 5; i++) begin
      cyc(); present(1'b1, 1'b0, 1'b1, 5'd6, 5'd0, 1'b0, 5'd0, 1'b0);
      chk($sformatf("waw_stall%0d", i), 32'(bus.issue_stall), 1);
      chk($sformatf("waw_we%0d", i), 32'(bus.mul_we), 0);
    end
    chk("waw_wbv", 32'(bus.wb_valid), 1);
    chk("waw_wbd", 32'(bus.wb_dst), 6);
    cyc(); present(1'b1, 1'b0, 1'b1, 5'd6, 5'd0, 1'b0, 5'd0, 1'b0);
    chk("waw_stall6", 32'(bus.issue_stall), 0);

    // Mid-operation reset with an issue presented
    cyc(); present(1'b1, 1'b1, 1'b1, 5'd3, 5'd1, 1'b1, 5'd2, 1'b1);
    cyc(); present(1'b1, 1'b1, 1'b1, 5'd4, 5'd1, 1'b1, 5'd2, 1'b1);
    cyc(); present(1'b1, 1'b1, 1'b1, 5'd5, 5'd1, 1'b1, 5'd2, 1'b1);
    cyc();
    reset = 1'b1;
    present(1'b1, 1'b1, 1'b1, 5'd11, 5'd1, 1'b1, 5'd2, 1'b1);
    chk("mrst_infl3", 32'(bus.inflight), 3);
    chk("mrst_we", 32'(bus.mul_we), 0);
    cyc();
    reset = 1'b0;
    present(1'b1, 1'b0, 1'b1, 5'd12, 5'd3, 1'b1, 5'd4, 1'b1);
    chk("mrst_infl", 32'(bus.inflight), 0);
    chk("mrst_wbv", 32'(bus.wb_valid), 0);
    chk("mrst_busy", 32'(bus.busy), 0);
    chk("mrst_dep_stall", 32'(bus.issue_stall), 0);
    cyc(); idle();
    chk("mrst_after", 32'(bus.inflight), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
